uncache_ctrl: RTL

- Uncached-access engine downstream of the MEM-stage cache select/prep logic.
- Consumes the uncached request: uncache_valid, store enable (DMWen_uncache), physical address, byte strobe, store data and size.
- Drives a single-beat read or write on the shared cache/AXI-bridge interface.
- Returns the response as uncache_Out and MEM_unCache_data_ok, the signals the cache-select mux forwards to the pipeline.

---
 rtl/uncache_pkg.sv | 37 +++
 rtl/uncache_ctrl.sv | 119 +++++++++++
 2 files changed

// File: rtl/uncache_pkg.sv
// Shared encodings for the uncached-access engine: FSM states, MEM size codes
// and the bridge transfer-type codes, plus the size-to-type mapping.
package uncache_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_REQ  = 3'd1;
  localparam logic [2:0] ST_RD_WAIT = 3'd2;
  localparam logic [2:0] ST_WR_REQ  = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    RD_REQ  = ST_RD_REQ,
    RD_WAIT = ST_RD_WAIT,
    WR_REQ  = ST_WR_REQ,
    DONE    = ST_DONE
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [2:0] TYPE_BYTE = 3'b000;
  localparam logic [2:0] TYPE_HALF = 3'b001;
  localparam logic [2:0] TYPE_WORD = 3'b010;
  localparam logic [2:0] TYPE_LINE = 3'b100;

  // Size 11 has no bridge meaning of its own and is issued as a word access.
  function automatic logic [2:0] size_to_type(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: size_to_type = TYPE_BYTE;
      SZ_HALF: size_to_type = TYPE_HALF;
      default: size_to_type = TYPE_WORD;
    endcase
  endfunction

endpackage

// File: rtl/uncache_ctrl.sv
// Uncached-access engine: latches one MEM-stage request, issues a single-beat
// read or write on the shared bridge port and returns a one-cycle data_ok.
// Address/type/strobe/data outputs are driven only while the matching request
// is up, so the bridge port reads all-zero when idle.
module uncache_ctrl
  import uncache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uncache_valid,
  input  logic              DMWen_uncache,
  input  logic [ADDR_W-1:0] MEM_Paddr,
  input  logic [1:0]        MEM_size,
  input  logic [3:0]        MEM_wstrb,
  input  logic [DATA_W-1:0] MEM_wdata,
  output logic              uncache_addr_ok,
  output logic              MEM_unCache_data_ok,
  output logic [DATA_W-1:0] uncache_Out,
  output logic              MEM_uncache_rd_req,
  output logic [2:0]        MEM_uncache_rd_type,
  output logic [ADDR_W-1:0] MEM_uncache_rd_addr,
  input  logic              rd_rdy,
  input  logic              ret_valid,
  input  logic              ret_last,
  input  logic [DATA_W-1:0] ret_data,
  output logic              MEM_uncache_wr_req,
  output logic [2:0]        MEM_uncache_wr_type,
  output logic [ADDR_W-1:0] MEM_uncache_wr_addr,
  output logic [3:0]        MEM_uncache_wr_wstrb,
  output logic [DATA_W-1:0] MEM_uncache_wr_data,
  input  logic              wr_rdy
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [2:0]          type_q;
  logic [3:0]          wstrb_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   out_q;
  logic                accept;

  assign accept      = (state_q == IDLE) && uncache_valid;
  assign uncache_Out = out_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Request latch: captured once at acceptance, so later input changes in MEM
  // cannot disturb the access in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q  <= '0;
      type_q  <= TYPE_BYTE;
      wstrb_q <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      addr_q  <= MEM_Paddr;
      type_q  <= size_to_type(MEM_size);
      wstrb_q <= MEM_wstrb;
      wdata_q <= MEM_wdata;
    end
  end

  // Load result: only the last return beat is kept; stores leave it untouched.
  always_ff @(posedge clk) begin
    if (!rst)                                               out_q <= '0;
    else if (state_q == RD_WAIT && ret_valid && ret_last)   out_q <= ret_data;
  end

  // Next-state and bridge-port outputs.
  always_comb begin
    state_d              = state_q;
    uncache_addr_ok      = 1'b0;
    MEM_unCache_data_ok  = 1'b0;
    MEM_uncache_rd_req   = 1'b0;
    MEM_uncache_rd_type  = '0;
    MEM_uncache_rd_addr  = '0;
    MEM_uncache_wr_req   = 1'b0;
    MEM_uncache_wr_type  = '0;
    MEM_uncache_wr_addr  = '0;
    MEM_uncache_wr_wstrb = '0;
    MEM_uncache_wr_data  = '0;
    case (state_q)
      IDLE: begin
        uncache_addr_ok = uncache_valid;
        if (uncache_valid) state_d = DMWen_uncache ? WR_REQ : RD_REQ;
      end
      RD_REQ: begin
        MEM_uncache_rd_req  = 1'b1;
        MEM_uncache_rd_type = type_q;
        MEM_uncache_rd_addr = addr_q;
        if (rd_rdy) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (ret_valid && ret_last) state_d = DONE;
      end
      WR_REQ: begin
        MEM_uncache_wr_req   = 1'b1;
        MEM_uncache_wr_type  = type_q;
        MEM_uncache_wr_addr  = addr_q;
        MEM_uncache_wr_wstrb = wstrb_q;
        MEM_uncache_wr_data  = wdata_q;
        if (wr_rdy) state_d = DONE;
      end
      DONE: begin
        MEM_unCache_data_ok = 1'b1;
        state_d             = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
